// File: rtl/mem_stage.sv
// Memory-access stage between EX and WB: issues loads/stores over a req/ack data bus,
// handles byte/half/word/double lanes with sign or zero extension, and flags misaligned accesses.
module mem_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int RD_W   = 5,
    localparam int LANES = DATA_W / 8,
    localparam int OFF_W = $clog2(LANES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    input  logic              ctrl_mem_read_i,
    input  logic              ctrl_mem_write_i,
    input  logic [1:0]        mem_size_i,
    input  logic              mem_unsigned_i,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic [DATA_W-1:0] mem_write_data_i,
    input  logic              wb_en_i,
    input  logic [RD_W-1:0]   wd_i,
    output logic              stall_req_o,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] alu_result_o,
    output logic [DATA_W-1:0] mem_read_data_o,
    output logic              wb_en_o,
    output logic [RD_W-1:0]   wd_o,
    output logic              misalign_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [LANES-1:0]  bus_sel_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic              bus_ack_i,
    input  logic [DATA_W-1:0] bus_rdata_i,
    output logic              dbg_state
);

    // Handshake: bus_req_o rises with the captured request and stays high, with every bus
    // output frozen, until the first cycle bus_ack_i is sampled high; that cycle completes it.
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUS  = 1'b1;

    localparam logic [DATA_W-1:0] ONE_D = {{(DATA_W-1){1'b0}}, 1'b1};
    localparam logic [LANES-1:0]  ONE_L = {{(LANES-1){1'b0}}, 1'b1};

    logic [0:0]       state;
    logic [1:0]       size_q;
    logic [OFF_W-1:0] off_q;
    logic             uns_q;

    logic              is_mem;
    logic              misaligned;
    logic              size_ok;
    logic              legal;
    logic [3:0]        nbytes;
    logic [LANES-1:0]  base_sel;
    logic [DATA_W-1:0] rep_wdata;
    logic [7:0]        nbits;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] ld_mask;
    logic              ld_sign;
    logic [DATA_W-1:0] load_val;

    assign dbg_state = state;
    assign is_mem    = ctrl_mem_read_i | ctrl_mem_write_i;

    always_comb begin
        misaligned = ((mem_size_i == 2'b01) & alu_result_i[0])
                   | ((mem_size_i == 2'b10) & (|alu_result_i[1:0]))
                   | ((mem_size_i == 2'b11) & (|alu_result_i[2:0]));
        size_ok = (mem_size_i != 2'b11) || (DATA_W == 64);
        legal   = size_ok & ~misaligned;
    end

    assign stall_req_o = ((state == IDLE) & in_valid_i & is_mem & legal)
                       | ((state == BUS) & ~bus_ack_i);

    // Lane mask and store-data replication for the request being accepted.
    always_comb begin
        nbytes   = 4'd1 << mem_size_i;
        base_sel = (nbytes >= 4'(LANES)) ? '1 : ((ONE_L << nbytes) - ONE_L);
        case (mem_size_i)
            2'b00:   rep_wdata = {LANES{mem_write_data_i[7:0]}};
            2'b01:   rep_wdata = {(LANES/2){mem_write_data_i[15:0]}};
            2'b10:   rep_wdata = {(DATA_W/32){mem_write_data_i[31:0]}};
            default: rep_wdata = mem_write_data_i;
        endcase
    end

    // Load extraction: shift the addressed lanes down, mask to size, fill from the top bit.
    always_comb begin
        shifted  = bus_rdata_i >> {off_q, 3'b000};
        nbits    = 8'd8 << size_q;
        ld_mask  = (nbits >= 8'(DATA_W)) ? '1 : ((ONE_D << nbits) - ONE_D);
        ld_sign  = |(shifted & (ld_mask ^ (ld_mask >> 1)));
        load_val = (shifted & ld_mask) | ((~uns_q & ld_sign) ? ~ld_mask : '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            size_q          <= '0;
            off_q           <= '0;
            uns_q           <= 1'b0;
            out_valid_o     <= 1'b0;
            alu_result_o    <= '0;
            mem_read_data_o <= '0;
            wb_en_o         <= 1'b0;
            wd_o            <= '0;
            misalign_o      <= 1'b0;
            bus_req_o       <= 1'b0;
            bus_we_o        <= 1'b0;
            bus_addr_o      <= '0;
            bus_sel_o       <= '0;
            bus_wdata_o     <= '0;
        end else begin
            out_valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid_i) begin
                        // Pass-through fields are loaded at accept; WB only looks at them on out_valid_o.
                        alu_result_o    <= alu_result_i;
                        wd_o            <= wd_i;
                        mem_read_data_o <= '0;
                        if (!is_mem) begin
                            out_valid_o <= 1'b1;
                            wb_en_o     <= wb_en_i;
                            misalign_o  <= 1'b0;
                        end else if (!legal) begin
                            out_valid_o <= 1'b1;
                            wb_en_o     <= 1'b0;
                            misalign_o  <= 1'b1;
                        end else begin
                            wb_en_o     <= wb_en_i;
                            misalign_o  <= 1'b0;
                            bus_req_o   <= 1'b1;
                            bus_we_o    <= ctrl_mem_write_i;
                            bus_addr_o  <= alu_result_i[ADDR_W-1:0] & ~ADDR_W'(LANES - 1);
                            bus_sel_o   <= base_sel << alu_result_i[OFF_W-1:0];
                            bus_wdata_o <= rep_wdata;
                            size_q      <= mem_size_i;
                            off_q       <= alu_result_i[OFF_W-1:0];
                            uns_q       <= mem_unsigned_i;
                            state       <= BUS;
                        end
                    end
                end
                BUS: begin
                    if (bus_ack_i) begin
                        bus_req_o       <= 1'b0;
                        out_valid_o     <= 1'b1;
                        mem_read_data_o <= bus_we_o ? '0 : load_val;
                        state           <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a 32-bit and a 64-bit instance share stimulus, one active at a time,
// checked against an arithmetic model of lane extraction, lane masks and store replication.
module tb_mem_stage;

    typedef struct {
        logic [63:0] alu;
        logic [63:0] mrd;
        logic        wb;
        logic [4:0]  wd;
        logic        mis;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        sel64;
    logic        in_valid, rd, wr, uns, wbe, ack;
    logic [1:0]  size;
    logic [63:0] alu, wdata, rdata;
    logic [4:0]  wd;

    logic        stall32, ov32, wb32, mis32, req32, we32, st32;
    logic [31:0] alu32, mrd32, addr32, wdat32;
    logic [4:0]  wd32;
    logic [3:0]  sel32;

    logic        stall64, ov64, wb64, mis64, req64, we64, st64;
    logic [63:0] alu64, mrd64, wdat64;
    logic [31:0] addr64;
    logic [4:0]  wd64;
    logic [7:0]  sel64_o;

    mem_stage #(.DATA_W(32), .ADDR_W(32), .RD_W(5)) dut32 (
        .clk(clk), .rst(rst), .in_valid_i(in_valid & ~sel64),
        .ctrl_mem_read_i(rd), .ctrl_mem_write_i(wr), .mem_size_i(size), .mem_unsigned_i(uns),
        .alu_result_i(alu[31:0]), .mem_write_data_i(wdata[31:0]), .wb_en_i(wbe), .wd_i(wd),
        .stall_req_o(stall32), .out_valid_o(ov32), .alu_result_o(alu32), .mem_read_data_o(mrd32),
        .wb_en_o(wb32), .wd_o(wd32), .misalign_o(mis32), .bus_req_o(req32), .bus_we_o(we32),
        .bus_addr_o(addr32), .bus_sel_o(sel32), .bus_wdata_o(wdat32),
        .bus_ack_i(ack & ~sel64), .bus_rdata_i(rdata[31:0]), .dbg_state(st32)
    );

    mem_stage #(.DATA_W(64), .ADDR_W(32), .RD_W(5)) dut64 (
        .clk(clk), .rst(rst), .in_valid_i(in_valid & sel64),
        .ctrl_mem_read_i(rd), .ctrl_mem_write_i(wr), .mem_size_i(size), .mem_unsigned_i(uns),
        .alu_result_i(alu), .mem_write_data_i(wdata), .wb_en_i(wbe), .wd_i(wd),
        .stall_req_o(stall64), .out_valid_o(ov64), .alu_result_o(alu64), .mem_read_data_o(mrd64),
        .wb_en_o(wb64), .wd_o(wd64), .misalign_o(mis64), .bus_req_o(req64), .bus_we_o(we64),
        .bus_addr_o(addr64), .bus_sel_o(sel64_o), .bus_wdata_o(wdat64),
        .bus_ack_i(ack & sel64), .bus_rdata_i(rdata), .dbg_state(st64)
    );

    logic        mon_stall, mon_req, mon_we, mon_ov, mon_wb, mon_mis;
    logic [63:0] mon_addr, mon_wdata, mon_mrd, mon_alu;
    logic [7:0]  mon_sel;
    logic [4:0]  mon_wd;
    always_comb begin
        mon_stall = sel64 ? stall64 : stall32;
        mon_req   = sel64 ? req64 : req32;
        mon_we    = sel64 ? we64 : we32;
        mon_ov    = sel64 ? ov64 : ov32;
        mon_wb    = sel64 ? wb64 : wb32;
        mon_mis   = sel64 ? mis64 : mis32;
        mon_addr  = sel64 ? {32'b0, addr64} : {32'b0, addr32};
        mon_wdata = sel64 ? wdat64 : {32'b0, wdat32};
        mon_mrd   = sel64 ? mrd64 : {32'b0, mrd32};
        mon_alu   = sel64 ? alu64 : {32'b0, alu32};
        mon_sel   = sel64 ? sel64_o : {4'b0, sel32};
        mon_wd    = sel64 ? wd64 : wd32;
    end

    int n_cmp = 0;
    int n_bad = 0;
    exp_t q32[$];
    exp_t q64[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- model ----------------
    function automatic logic m_legal(input logic [63:0] a, input logic [1:0] sz, input int w);
        int nb;
        nb = 1 << sz;
        if (sz == 2'b11 && w == 32) return 1'b0;
        return (int'(a[2:0]) % nb) == 0;
    endfunction

    function automatic logic [63:0] m_load(input logic [63:0] rdv, input logic [63:0] a,
                                           input logic [1:0] sz, input logic u, input int w);
        int nb, off;
        logic [63:0] v;
        nb  = 1 << sz;
        off = int'(a[2:0]) % (w / 8);
        v   = '0;
        for (int i = 0; i < nb; i++) v[i*8 +: 8] = rdv[(off+i)*8 +: 8];
        if (!u && v[nb*8-1])
            for (int i = nb * 8; i < 64; i++) v[i] = 1'b1;
        if (w == 32) v[63:32] = '0;
        return v;
    endfunction

    function automatic logic [7:0] m_sel(input logic [63:0] a, input logic [1:0] sz, input int w);
        int nb, off;
        logic [7:0] s;
        nb  = 1 << sz;
        off = int'(a[2:0]) % (w / 8);
        s   = '0;
        for (int i = 0; i < w / 8; i++) s[i] = (i >= off) && (i < off + nb);
        return s;
    endfunction

    function automatic logic [63:0] m_wdata(input logic [63:0] d, input logic [1:0] sz, input int w);
        int nb;
        logic [63:0] r;
        nb = 1 << sz;
        r  = '0;
        for (int i = 0; i < w / 8; i++) r[i*8 +: 8] = d[(i % nb)*8 +: 8];
        return r;
    endfunction

    function automatic logic [63:0] m_addr(input logic [63:0] a, input int w);
        return {32'b0, a[31:0] & ~32'(w / 8 - 1)};
    endfunction

    // ---------------- compare process ----------------
    task automatic cmp_out(input string tag, input exp_t e, input logic [63:0] a,
                           input logic [63:0] m, input logic w, input logic [4:0] d, input logic mi);
        chk({tag, "_misalign"}, 64'(mi), 64'(e.mis));
        chk({tag, "_wb_en"}, 64'(w), 64'(e.wb));
        if (!e.mis) begin
            chk({tag, "_alu"}, a, e.alu);
            chk({tag, "_rdata"}, m, e.mrd);
            chk({tag, "_wd"}, 64'(d), 64'(e.wd));
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (ov32) begin
                if (q32.size() == 0) chk("ov32_unexpected", 64'(ov32), 64'd0);
                else cmp_out("out32", q32.pop_front(), {32'b0, alu32}, {32'b0, mrd32}, wb32, wd32, mis32);
            end
            if (ov64) begin
                if (q64.size() == 0) chk("ov64_unexpected", 64'(ov64), 64'd0);
                else cmp_out("out64", q64.pop_front(), alu64, mrd64, wb64, wd64, mis64);
            end
        end
    end

    // ---------------- driver ----------------
    logic [63:0] last_addr, last_wdata;
    logic [7:0]  last_sel;
    logic        last_we;
    int          last_stall;

    task automatic do_op(input logic r, input logic w_, input logic [1:0] sz, input logic u,
                         input logic [63:0] a, input logic [63:0] d, input logic wb_,
                         input logic [4:0] rdi, input logic [63:0] rdv, input int k);
        int   w;
        logic lg, mem;
        exp_t e;
        w   = sel64 ? 64 : 32;
        mem = r | w_;
        lg  = m_legal(a, sz, w);
        e.alu = (w == 32) ? {32'b0, a[31:0]} : a;
        e.wd  = rdi;
        e.mis = mem && !lg;
        e.wb  = (mem && !lg) ? 1'b0 : wb_;
        e.mrd = (!mem || w_) ? 64'd0 : m_load(rdv, a, sz, u, w);
        if (sel64) q64.push_back(e);
        else q32.push_back(e);
        in_valid = 1'b1; rd = r; wr = w_; size = sz; uns = u;
        alu = a; wdata = d; wbe = wb_; wd = rdi;
        #1;
        chk("stall_t0", 64'(mon_stall), 64'(mem && lg));
        last_stall = 0;
        if (!(mem && lg)) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk("no_bus_req", 64'(mon_req), 64'd0);
        end else begin
            last_stall = 1;
            @(posedge clk); #1;
            chk("bus_req", 64'(mon_req), 64'd1);
            chk("bus_we", 64'(mon_we), 64'(w_));
            chk("bus_addr", mon_addr, m_addr(a, w));
            chk("bus_sel", 64'(mon_sel), 64'(m_sel(a, sz, w)));
            if (w_) chk("bus_wdata", mon_wdata, m_wdata(d, sz, w));
            last_addr = mon_addr; last_sel = mon_sel; last_wdata = mon_wdata; last_we = mon_we;
            for (int i = 1; i < k; i++) begin
                chk("stall_wait", 64'(mon_stall), 64'd1);
                last_stall++;
                @(posedge clk); #1;
                chk("req_hold", 64'(mon_req), 64'd1);
            end
            ack = 1'b1; rdata = rdv;
            #1;
            chk("stall_ack", 64'(mon_stall), 64'd0);
            @(posedge clk); #1;
            ack = 1'b0; rdata = '0; in_valid = 1'b0;
            chk("req_drop", 64'(mon_req), 64'd0);
        end
    endtask

    // ---------------- directed sequence ----------------
    int t_a;
    initial begin
        rst = 1'b0; sel64 = 1'b0;
        in_valid = 1'b0; rd = 1'b0; wr = 1'b0; size = 2'b00; uns = 1'b0; wbe = 1'b0; ack = 1'b0;
        alu = '0; wdata = '0; rdata = '0; wd = '0;
        @(posedge clk); #1;
        chk("rst_ov32", 64'(ov32), 64'd0);
        chk("rst_req32", 64'(req32), 64'd0);
        chk("rst_alu32", 64'(alu32), 64'd0);
        chk("rst_mrd32", 64'(mrd32), 64'd0);
        chk("rst_sel32", 64'(sel32), 64'd0);
        chk("rst_mis32", 64'(mis32), 64'd0);
        chk("rst_state32", 64'(st32), 64'd0);
        chk("rst_req64", 64'(req64), 64'd0);
        chk("rst_mrd64", mrd64, 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Non-memory pass-through.
        do_op(1'b0, 1'b0, 2'b10, 1'b0, 64'h1234, 64'd0, 1'b1, 5'd5, 64'd0, 1);
        chk("nm_ov_lit", 64'(mon_ov), 64'd1);
        chk("nm_alu_lit", mon_alu, 64'h1234);
        chk("nm_wd_lit", 64'(mon_wd), 64'd5);

        // Signed / unsigned byte load at 0x1003, ack on the third cycle.
        do_op(1'b1, 1'b0, 2'b00, 1'b0, 64'h1003, 64'd0, 1'b1, 5'd7, 64'h8000_0000, 3);
        chk("lb_sel_lit", 64'(last_sel), 64'h8);
        chk("lb_addr_lit", last_addr, 64'h1000);
        chk("lb_stall_lit", 64'(last_stall), 64'd3);
        chk("lb_data_lit", mon_mrd, 64'hFFFF_FF80);
        do_op(1'b1, 1'b0, 2'b00, 1'b1, 64'h1003, 64'd0, 1'b1, 5'd7, 64'h8000_0000, 3);
        chk("lbu_data_lit", mon_mrd, 64'h80);

        // Half store.
        do_op(1'b0, 1'b1, 2'b01, 1'b0, 64'h2002, 64'hBEEF, 1'b0, 5'd0, 64'hDEAD_DEAD, 2);
        chk("sh_we_lit", 64'(last_we), 64'd1);
        chk("sh_sel_lit", 64'(last_sel), 64'hC);
        chk("sh_wdata_lit", last_wdata, 64'hBEEF_BEEF);
        chk("sh_data_lit", mon_mrd, 64'd0);

        // Misaligned word and illegal double on the 32-bit build.
        do_op(1'b1, 1'b0, 2'b10, 1'b0, 64'h3001, 64'd0, 1'b1, 5'd3, 64'd0, 1);
        chk("mis_lit", 64'(mon_mis), 64'd1);
        chk("mis_wb_lit", 64'(mon_wb), 64'd0);
        do_op(1'b1, 1'b0, 2'b11, 1'b0, 64'h3000, 64'd0, 1'b1, 5'd3, 64'd0, 1);
        chk("ld64_on32_lit", 64'(mon_mis), 64'd1);

        // Back-to-back zero-wait loads, then a non-memory op straight after.
        do_op(1'b1, 1'b0, 2'b10, 1'b0, 64'h4000, 64'd0, 1'b1, 5'd9, 64'h1234_5678, 1);
        t_a = cyc;
        chk("b2b_a_lit", mon_mrd, 64'h1234_5678);
        do_op(1'b1, 1'b0, 2'b01, 1'b0, 64'h4002, 64'd0, 1'b1, 5'd10, 64'h8001_0000, 1);
        chk("b2b_gap", 64'(cyc - t_a), 64'd2);
        chk("b2b_b_lit", mon_mrd, 64'hFFFF_8001);
        do_op(1'b0, 1'b0, 2'b00, 1'b0, 64'h5555, 64'd0, 1'b1, 5'd11, 64'd0, 1);
        do_op(1'b1, 1'b0, 2'b01, 1'b1, 64'h1002, 64'd0, 1'b1, 5'd12, 64'hF00D_0000, 2);

        // Reset while a request is outstanding; a late ack must be ignored.
        in_valid = 1'b1; rd = 1'b1; wr = 1'b0; size = 2'b10; alu = 64'h5000;
        @(posedge clk); #1;
        chk("rstbus_req_before", 64'(req32), 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("rstbus_req_async", 64'(req32), 64'd0);
        chk("rstbus_alu", 64'(alu32), 64'd0);
        chk("rstbus_sel", 64'(sel32), 64'd0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        ack = 1'b1; rdata = 64'hFFFF_FFFF;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("rstbus_late_req", 64'(req32), 64'd0);
            chk("rstbus_late_ov", 64'(ov32), 64'd0);
            chk("rstbus_late_mrd", 64'(mrd32), 64'd0);
        end
        ack = 1'b0; rdata = '0;
        @(posedge clk); #1;

        // 64-bit build.
        sel64 = 1'b1;
        do_op(1'b1, 1'b0, 2'b11, 1'b0, 64'h8, 64'd0, 1'b1, 5'd1, 64'h0123_4567_89AB_CDEF, 1);
        chk("ld_lit", mon_mrd, 64'h0123_4567_89AB_CDEF);
        do_op(1'b1, 1'b0, 2'b10, 1'b0, 64'h14, 64'd0, 1'b1, 5'd2, 64'h8000_0000_0000_0000, 2);
        chk("lw64_lit", mon_mrd, 64'hFFFF_FFFF_8000_0000);
        do_op(1'b0, 1'b1, 2'b01, 1'b0, 64'h6, 64'hBEEF, 1'b0, 5'd0, 64'd0, 1);
        chk("sh64_sel_lit", 64'(last_sel), 64'hC0);
        chk("sh64_wdata_lit", last_wdata, 64'hBEEF_BEEF_BEEF_BEEF);
        do_op(1'b0, 1'b1, 2'b11, 1'b0, 64'h10, 64'h1122_3344_5566_7788, 1'b0, 5'd0, 64'd0, 1);
        do_op(1'b1, 1'b0, 2'b00, 1'b1, 64'h1003, 64'd0, 1'b1, 5'd4, 64'h0000_0000_AB00_0000, 1);
        do_op(1'b1, 1'b0, 2'b11, 1'b0, 64'hC, 64'd0, 1'b1, 5'd6, 64'd0, 1);
        chk("mis64_lit", 64'(mon_mis), 64'd1);

        repeat (3) @(posedge clk);
        #1;
        chk("pending32", 64'(q32.size()), 64'd0);
        chk("pending64", 64'(q64.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
